// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the sync_fifo_flags FIFO: default sizes,
// the occupancy-counter width helper and the sticky error record.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_DEPTH  = 8;

  // Counter must hold every value 0..depth inclusive
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo_flags: DEPTH x DATA_W registers with one
// synchronous write port and one asynchronous (combinational) read port.
// The array is deliberately not reset; the owner tracks which entries hold data.
module sync_fifo_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [PTR_W-1:0]  wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [PTR_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write the incoming word into the addressed slot on the rising edge
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock show-ahead FIFO with occupancy count, almost-full/almost-empty
// flags and sticky overflow/underflow errors. Any DEPTH >= 2 is supported;
// pointers wrap explicitly at DEPTH-1.
// Optional feature macro: SYNC_FIFO_WATERMARK_EN enables the peak-occupancy
// register behind max_count_o; without it max_count_o is tied to 0.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [cnt_w(DEPTH)-1:0]    count_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  output logic [cnt_w(DEPTH)-1:0]    max_count_o
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  fifo_err_t         err_q, err_d;
  logic              pushAcc, popAcc;
  logic [DATA_W-1:0] memRdData;

  // Flags are decoded only from the registered count, never from push/pop
  assign full_o         = (count_q == DEPTH_C);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= AF_C);
  assign almost_empty_o = (count_q <= AE_C);
  assign count_o        = count_q;
  assign overflow_o     = err_q.overflow;
  assign underflow_o    = err_q.underflow;

  // A push into a full FIFO is fine when a pop frees the head slot on the same edge
  assign pushAcc = push_i && (!full_o || pop_i);
  assign popAcc  = pop_i && !empty_o;

  // Next pointers, count and sticky errors from the accepted operations
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    err_d   = err_q;
    if (pushAcc) begin
      wrPtr_d = (wrPtr_q == LAST_C) ? '0 : wrPtr_q + PTR_W'(1);
    end
    if (popAcc) begin
      rdPtr_d = (rdPtr_q == LAST_C) ? '0 : rdPtr_q + PTR_W'(1);
    end
    unique case ({pushAcc, popAcc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push_i && !pushAcc) begin
      err_d.overflow = 1'b1;
    end
    if (pop_i && empty_o) begin
      err_d.underflow = 1'b1;
    end
  end

  // Control state register; reset wins over any push/pop in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      err_q   <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

`ifdef SYNC_FIFO_WATERMARK_EN
  logic [CNT_W-1:0] maxCount_q;

  // Track peak occupancy using the next count so it moves on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      maxCount_q <= '0;
    end else if (count_d > maxCount_q) begin
      maxCount_q <= count_d;
    end
  end

  assign max_count_o = maxCount_q;
`else
  assign max_count_o = '0;
`endif

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (pushAcc && !reset),
    .wr_addr_i (wrPtr_q),
    .wr_data_i (push_data_i),
    .rd_addr_i (rdPtr_q),
    .rd_data_o (memRdData)
  );

  // Show-ahead head word, forced to zero while nothing is stored
  assign pop_data_o = empty_o ? '0 : memRdData;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags (DATA_W=16, DEPTH=8, AF=6, AE=2).
// Uses a queue-based reference model plus a table of directed vectors.
// Honours SYNC_FIFO_WATERMARK_EN for the max_count_o expectations.
module tb_sync_fifo_flags;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              push_i;
  logic [DATA_W-1:0] push_data_i;
  logic              pop_i;
  logic [DATA_W-1:0] pop_data_o;
  logic              full_o, empty_o, almost_full_o, almost_empty_o;
  logic [3:0]        count_o, max_count_o;
  logic              overflow_o, underflow_o;

  int checks = 0;
  int fails  = 0;

  // Reference model state
  logic [DATA_W-1:0] modelQ [$];
  bit                modelOvf, modelUnf;
  int                modelMax;

  typedef struct {
    logic        push;
    logic [15:0] data;
    logic        pop;
    int          expCount;
    logic [15:0] expHead;
    logic        expFull;
    logic        expEmpty;
    logic        expAf;
    logic        expAe;
  } vec_t;

  vec_t vecs [16];

  sync_fifo_flags #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .push_i         (push_i),
    .push_data_i    (push_data_i),
    .pop_i          (pop_i),
    .pop_data_o     (pop_data_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o),
    .max_count_o    (max_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge of FIFO rules applied to the queue model
  task automatic modelStep(input bit rst, input bit push, input logic [15:0] data, input bit pop);
    bit popOk, pushOk;
    if (rst) begin
      modelQ.delete();
      modelOvf = 0;
      modelUnf = 0;
      modelMax = 0;
      return;
    end
    popOk  = pop && (modelQ.size() > 0);
    pushOk = push && ((modelQ.size() < DEPTH) || pop);
    if (pop && modelQ.size() == 0) modelUnf = 1;
    if (push && !pushOk) modelOvf = 1;
    if (popOk) void'(modelQ.pop_front());
    if (pushOk) modelQ.push_back(data);
    if (modelQ.size() > modelMax) modelMax = modelQ.size();
  endtask

  task automatic applyStimulus(input bit rst, input bit push, input logic [15:0] data, input bit pop);
    reset       = rst;
    push_i      = push;
    push_data_i = data;
    pop_i       = pop;
    @(posedge clk);
    #1;
    modelStep(rst, push, data, pop);
  endtask

  task automatic checkOutput(input string tag);
    int n;
    logic [15:0] head;
    int expMax;
    n    = modelQ.size();
    head = (n > 0) ? modelQ[0] : 16'h0;
`ifdef SYNC_FIFO_WATERMARK_EN
    expMax = modelMax;
`else
    expMax = 0;
`endif
    check({tag, ".count"},    32'(count_o),        32'(n));
    check({tag, ".head"},     32'(pop_data_o),     32'(head));
    check({tag, ".full"},     32'(full_o),         32'(n == DEPTH));
    check({tag, ".empty"},    32'(empty_o),        32'(n == 0));
    check({tag, ".afull"},    32'(almost_full_o),  32'(n >= AF));
    check({tag, ".aempty"},   32'(almost_empty_o), 32'(n <= AE));
    check({tag, ".overflow"}, 32'(overflow_o),     32'(modelOvf));
    check({tag, ".underflow"},32'(underflow_o),    32'(modelUnf));
    check({tag, ".maxcount"}, 32'(max_count_o),    32'(expMax));
  endtask

  initial begin
    // Directed table: push 1..8 then pop 8, expectations from the FIFO rules
    for (int k = 1; k <= 8; k++) begin
      vecs[k-1].push     = 1'b1;
      vecs[k-1].data     = 16'(k);
      vecs[k-1].pop      = 1'b0;
      vecs[k-1].expCount = k;
      vecs[k-1].expHead  = 16'h0001;
      vecs[k-1].expFull  = (k == 8);
      vecs[k-1].expEmpty = 1'b0;
      vecs[k-1].expAf    = (k >= 6);
      vecs[k-1].expAe    = (k <= 2);
    end
    for (int k = 1; k <= 8; k++) begin
      vecs[k+7].push     = 1'b0;
      vecs[k+7].data     = 16'h0;
      vecs[k+7].pop      = 1'b1;
      vecs[k+7].expCount = 8 - k;
      vecs[k+7].expHead  = (k < 8) ? 16'(k + 1) : 16'h0;
      vecs[k+7].expFull  = 1'b0;
      vecs[k+7].expEmpty = (k == 8);
      vecs[k+7].expAf    = ((8 - k) >= 6);
      vecs[k+7].expAe    = ((8 - k) <= 2);
    end

    reset = 1'b1; push_i = 1'b0; pop_i = 1'b0; push_data_i = '0;
    applyStimulus(1, 0, 16'h0, 0);
    applyStimulus(1, 0, 16'h0, 0);
    check("reset.count", 32'(count_o), 32'd0);
    check("reset.empty", 32'(empty_o), 32'd1);
    check("reset.aempty", 32'(almost_empty_o), 32'd1);
    check("reset.popdata", 32'(pop_data_o), 32'd0);
    checkOutput("reset");

    // Tests 1 and 2: fill and drain from the table
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].pop) check("table.headBeforePop", 32'(pop_data_o), 32'(i - 7));
      applyStimulus(0, vecs[i].push, vecs[i].data, vecs[i].pop);
      check("table.count",  32'(count_o),        32'(vecs[i].expCount));
      check("table.head",   32'(pop_data_o),     32'(vecs[i].expHead));
      check("table.full",   32'(full_o),         32'(vecs[i].expFull));
      check("table.empty",  32'(empty_o),        32'(vecs[i].expEmpty));
      check("table.afull",  32'(almost_full_o),  32'(vecs[i].expAf));
      check("table.aempty", 32'(almost_empty_o), 32'(vecs[i].expAe));
      check("table.noerr",  32'({overflow_o, underflow_o}), 32'd0);
    end

    // Test 3: overflow while full
    for (int k = 0; k < DEPTH; k++) applyStimulus(0, 1, 16'h0100 + 16'(k), 0);
    applyStimulus(0, 1, 16'hDEAD, 0);
    check("ovf.set", 32'(overflow_o), 32'd1);
    check("ovf.count", 32'(count_o), 32'd8);
    checkOutput("ovf");
    applyStimulus(0, 0, 16'h0, 0);
    check("ovf.sticky", 32'(overflow_o), 32'd1);

    // Test 4: simultaneous push/pop while full across pointer wrap
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1, 16'h0200 + 16'(k), 1);
      checkOutput("fullpp");
    end
    while (modelQ.size() > 0) begin
      check("drain.notDead", 32'(pop_data_o == 16'hDEAD), 32'd0);
      applyStimulus(0, 0, 16'h0, 1);
      checkOutput("drain");
    end

    // Test 5: pop with push while empty
    applyStimulus(0, 1, 16'h1234, 1);
    check("unf.set", 32'(underflow_o), 32'd1);
    check("unf.count", 32'(count_o), 32'd1);
    check("unf.head", 32'(pop_data_o), 32'h1234);
    checkOutput("unf");

    // Test 6: reset with count 5 while push/pop requested
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 16'h0300 + 16'(k), 0);
    check("pre.count", 32'(count_o), 32'd5);
    applyStimulus(1, 1, 16'hBEEF, 1);
    check("rst.count", 32'(count_o), 32'd0);
    check("rst.errs", 32'({overflow_o, underflow_o}), 32'd0);
    check("rst.max", 32'(max_count_o), 32'd0);
    checkOutput("rst");
    for (int k = 0; k < 7; k++) applyStimulus(0, 1, 16'(k * 3 + 1), 0);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 0, 16'h0, 1);
      checkOutput("wm");
    end
`ifdef SYNC_FIFO_WATERMARK_EN
    check("wm.max", 32'(max_count_o), 32'd7);
`else
    check("wm.max", 32'(max_count_o), 32'd0);
`endif

    // Randomised traffic with phases biased towards filling or draining
    for (int i = 0; i < 400; i++) begin
      bit rst, push, pop;
      int bias;
      bias = ((i / 50) % 2 == 0) ? 75 : 25;
      rst  = ($urandom_range(0, 99) == 0);
      push = ($urandom_range(0, 99) < bias);
      pop  = ($urandom_range(0, 99) < (100 - bias));
      applyStimulus(rst, push, 16'($urandom), pop);
      checkOutput("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
